// File: rtl/branch_prediction_unit.sv
// Fetch-stage next-PC predictor: 2-bit counter BHT for conditional branches,
// circular return-address stack for calls/returns, same-cycle prediction.
module branch_prediction_unit #(
  parameter int BHT_ADDR_WIDTH = 6,
  parameter int RAS_DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    if_pc,
  input  logic                           if_valid,
  input  logic                           if_stall,
  input  logic                           jal,
  input  logic                           jalr,
  input  logic                           B_type,
  input  logic [4:0]                     Rd,
  input  logic [4:0]                     Rs1,
  input  logic [31:0]                    imme,
  input  logic                           ex_update_valid,
  input  logic [31:0]                    ex_pc,
  input  logic                           ex_taken,
  output logic                           pred_taken,
  output logic [31:0]                    pred_target,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int BHT_ENTRIES = 1 << BHT_ADDR_WIDTH;
  localparam int PTR_W       = $clog2(RAS_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  logic [BHT_ADDR_WIDTH-1:0]      if_idx;
  logic [BHT_ADDR_WIDTH-1:0]      ex_idx;
  logic [BHT_ENTRIES-1:0][1:0]    bht_ctr;
  logic [RAS_DEPTH-1:0][31:0]     ras_entry;
  logic [PTR_W-1:0]               ras_ptr_reg;
  logic [PTR_W-1:0]               ras_ptr_next;
  logic [CNT_W-1:0]               ras_count_reg;
  logic [CNT_W-1:0]               ras_count_next;
  logic [31:0]                    pc_plus4;
  logic [31:0]                    pc_plus_imm;
  logic [31:0]                    ras_top;
  logic                           link_rd;
  logic                           link_rs1;
  logic                           is_return;
  logic                           is_call;
  logic                           is_coroutine;
  logic                           ras_empty;
  logic                           do_push;
  logic                           do_pop;
  logic                           do_replace;
  logic                           ras_en;
  logic                           ras_wr_en;
  logic [PTR_W-1:0]               ras_wr_ptr;
  logic                           unused_bits;

  assign if_idx      = if_pc[BHT_ADDR_WIDTH+1:2];
  assign ex_idx      = ex_pc[BHT_ADDR_WIDTH+1:2];
  assign unused_bits = ^{ex_pc[31:BHT_ADDR_WIDTH+2], ex_pc[1:0]};

  assign pc_plus4    = if_pc + 32'd4;
  assign pc_plus_imm = if_pc + imme;
  assign ras_top     = ras_entry[ras_ptr_reg];
  assign ras_empty   = (ras_count_reg == '0);
  assign ras_count   = ras_count_reg;

  // RISC-V jalr hint classification on link registers x1/x5
  assign link_rd      = (Rd == 5'd1) || (Rd == 5'd5);
  assign link_rs1     = (Rs1 == 5'd1) || (Rs1 == 5'd5);
  assign is_return    = link_rs1 && !link_rd;
  assign is_call      = link_rd && (!link_rs1 || (Rd == Rs1));
  assign is_coroutine = link_rd && link_rs1 && (Rd != Rs1);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    do_replace  = 1'b0;
    if (if_valid) begin
      if (jal) begin
        pred_taken  = 1'b1;
        pred_target = pc_plus_imm;
        do_push     = link_rd;
      end else if (B_type) begin
        if (bht_ctr[if_idx][1]) begin
          pred_taken  = 1'b1;
          pred_target = pc_plus_imm;
        end
      end else if (jalr) begin
        if (is_return) begin
          if (!ras_empty) begin
            pred_taken  = 1'b1;
            pred_target = {ras_top[31:1], 1'b0};
            do_pop      = 1'b1;
          end
        end else if (is_call) begin
          do_push = 1'b1;
        end else if (is_coroutine) begin
          if (!ras_empty) begin
            pred_taken  = 1'b1;
            pred_target = {ras_top[31:1], 1'b0};
            do_replace  = 1'b1;
          end else begin
            do_push = 1'b1;
          end
        end
      end
    end
  end

  // A held fetch repeats its prediction but must not touch the stack again
  assign ras_en     = if_valid && !if_stall;
  assign ras_wr_en  = ras_en && (do_push || do_replace);
  assign ras_wr_ptr = do_push ? ras_ptr_reg + PTR_W'(1) : ras_ptr_reg;

  always_comb begin
    ras_ptr_next   = ras_ptr_reg;
    ras_count_next = ras_count_reg;
    if (ras_en && do_push) begin
      ras_ptr_next = ras_ptr_reg + PTR_W'(1);
      if (ras_count_reg != CNT_W'(RAS_DEPTH))
        ras_count_next = ras_count_reg + CNT_W'(1);
    end else if (ras_en && do_pop) begin
      ras_ptr_next   = ras_ptr_reg - PTR_W'(1);
      ras_count_next = ras_count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_reg   <= '0;
      ras_count_reg <= '0;
    end else begin
      ras_ptr_reg   <= ras_ptr_next;
      ras_count_reg <= ras_count_next;
    end
  end

  // Full-stack pushes land on the oldest slot because the pointer wraps
  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    logic [31:0] entry_reg;
    always_ff @(posedge clk) begin
      if (rst)
        entry_reg <= '0;
      else if (ras_wr_en && (ras_wr_ptr == PTR_W'(gi)))
        entry_reg <= pc_plus4;
    end
    assign ras_entry[gi] = entry_reg;
  end

  // Counters are read combinationally; a same-cycle update shows next cycle
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
    logic [1:0] ctr_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        ctr_reg <= 2'b01;
      end else if (ex_update_valid && (ex_idx == BHT_ADDR_WIDTH'(gi))) begin
        if (ex_taken && (ctr_reg != 2'b11))
          ctr_reg <= ctr_reg + 2'd1;
        else if (!ex_taken && (ctr_reg != 2'b00))
          ctr_reg <= ctr_reg - 2'd1;
      end
    end
    assign bht_ctr[gi] = ctr_reg;
  end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Bench for branch_prediction_unit: directed vector table, then random traffic
// checked against a queue-based RAS / integer-counter BHT reference model.
module tb_branch_prediction_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_stall, jal, jalr, B_type;
  logic [4:0]  Rd, Rs1;
  logic [31:0] if_pc, imme, ex_pc;
  logic        ex_update_valid, ex_taken;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [2:0]  ras_count;

  branch_prediction_unit #(.BHT_ADDR_WIDTH(6), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid), .if_stall(if_stall),
    .jal(jal), .jalr(jalr), .B_type(B_type), .Rd(Rd), .Rs1(Rs1), .imme(imme),
    .ex_update_valid(ex_update_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .pred_taken(pred_taken), .pred_target(pred_target), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, valid, stall, jal, jalr, btype;
    logic [4:0]  rd, rs1;
    logic [31:0] pc, imme;
    logic        exv;
    logic [31:0] expc;
    logic        ext;
    logic        chk;
    logic        e_taken;
    logic [31:0] e_target;
    int          e_count;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: counters as ints, RAS as a queue whose back is the top
  int          bht_m [64];
  logic [31:0] ras_m [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_pred(input vec_t v, output logic t, output logic [31:0] tgt,
                                 output int op);
    logic lrd, lrs;
    lrd = (v.rd == 5'd1) || (v.rd == 5'd5);
    lrs = (v.rs1 == 5'd1) || (v.rs1 == 5'd5);
    t = 1'b0; tgt = v.pc + 32'd4; op = 0;
    if (!v.valid) return;
    if (v.jal) begin
      t = 1'b1; tgt = v.pc + v.imme;
      if (lrd) op = 1;
    end else if (v.btype) begin
      if (bht_m[v.pc[7:2]] >= 2) begin t = 1'b1; tgt = v.pc + v.imme; end
    end else if (v.jalr) begin
      if (lrs && !lrd) begin
        if (ras_m.size() > 0) begin t = 1'b1; tgt = ras_m[$] & ~32'd1; op = 2; end
      end else if (lrd && (!lrs || v.rd == v.rs1)) begin
        op = 1;
      end else if (lrd && lrs) begin
        if (ras_m.size() > 0) begin t = 1'b1; tgt = ras_m[$] & ~32'd1; op = 3; end
        else op = 1;
      end
    end
  endfunction

  function automatic void m_update(input vec_t v, input int op);
    if (v.rst) begin
      foreach (bht_m[i]) bht_m[i] = 1;
      ras_m.delete();
      return;
    end
    if (v.exv) begin
      if (v.ext) bht_m[v.expc[7:2]] = (bht_m[v.expc[7:2]] == 3) ? 3 : bht_m[v.expc[7:2]] + 1;
      else       bht_m[v.expc[7:2]] = (bht_m[v.expc[7:2]] == 0) ? 0 : bht_m[v.expc[7:2]] - 1;
    end
    if (v.valid && !v.stall) begin
      case (op)
        1: begin
          ras_m.push_back(v.pc + 32'd4);
          if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
        end
        2: void'(ras_m.pop_back());
        3: ras_m[ras_m.size()-1] = v.pc + 32'd4;
        default: ;
      endcase
    end
  endfunction

  task automatic run(input vec_t v, input bit from_table, input string tag);
    logic        mt;
    logic [31:0] mtgt;
    int          op, ecnt;
    logic        et;
    logic [31:0] etgt;
    rst = v.rst; if_valid = v.valid; if_stall = v.stall;
    jal = v.jal; jalr = v.jalr; B_type = v.btype;
    Rd = v.rd; Rs1 = v.rs1; if_pc = v.pc; imme = v.imme;
    ex_update_valid = v.exv; ex_pc = v.expc; ex_taken = v.ext;
    #2;
    m_pred(v, mt, mtgt, op);
    if (from_table) begin et = v.e_taken; etgt = v.e_target; ecnt = v.e_count; end
    else begin et = mt; etgt = mtgt; ecnt = ras_m.size(); end
    if (!v.rst && (!from_table || v.chk)) begin
      check({tag, " pred_taken"}, {31'd0, pred_taken}, {31'd0, et});
      check({tag, " pred_target"}, pred_target, etgt);
      check({tag, " ras_count"}, {29'd0, ras_count}, ecnt);
    end
    $display("%s rst=%0b pc=%08h j=%0b jr=%0b b=%0b rd=%0d rs1=%0d -> taken=%0b target=%08h cnt=%0d",
             tag, v.rst, v.pc, v.jal, v.jalr, v.btype, v.rd, v.rs1, pred_taken, pred_target, ras_count);
    @(posedge clk); #1;
    m_update(v, op);
  endtask

  function automatic vec_t vz(logic [31:0] pc, logic et, logic [31:0] etgt, int ecnt);
    vec_t v;
    v = '{default: 0};
    v.pc = pc; v.chk = 1'b1; v.e_taken = et; v.e_target = etgt; v.e_count = ecnt;
    return v;
  endfunction

  function automatic void add_idle(logic [31:0] pc, int c);
    vecs.push_back(vz(pc, 1'b0, pc + 32'd4, c));
  endfunction

  function automatic void add_br(logic et, logic exv, logic ext);
    vec_t v;
    v = vz(32'h100, et, et ? 32'h120 : 32'h104, 0);
    v.valid = 1'b1; v.btype = 1'b1; v.imme = 32'h20;
    v.exv = exv; v.expc = 32'h100; v.ext = ext;
    vecs.push_back(v);
  endfunction

  function automatic void add_ex(logic ext);
    vec_t v;
    v = vz(32'h100, 1'b0, 32'h104, 0);
    v.exv = 1'b1; v.expc = 32'h100; v.ext = ext;
    vecs.push_back(v);
  endfunction

  function automatic void add_jal(logic [31:0] pc, logic [31:0] im, int rd, int c);
    vec_t v;
    v = vz(pc, 1'b1, pc + im, c);
    v.valid = 1'b1; v.jal = 1'b1; v.rd = 5'(rd); v.imme = im;
    vecs.push_back(v);
  endfunction

  function automatic void add_jr(logic [31:0] pc, int rd, int rs1, logic st,
                                 logic et, logic [31:0] etgt, int c);
    vec_t v;
    v = vz(pc, et, etgt, c);
    v.valid = 1'b1; v.jalr = 1'b1; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.stall = st;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst_call(logic st);
    vec_t v;
    v = vz(32'h500, 1'b0, 32'h504, 0);
    v.rst = 1'b1; v.chk = 1'b0; v.valid = 1'b1; v.stall = st;
    v.jal = 1'b1; v.rd = 5'd1; v.imme = 32'h40;
    v.exv = 1'b1; v.expc = 32'h100; v.ext = 1'b1;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    // Reset, then BHT training and saturation at index of 0x100
    v = vz(32'h0, 1'b0, 32'h4, 0); v.rst = 1'b1; v.chk = 1'b0; vecs.push_back(v);
    add_idle(32'h100, 0);
    add_br(1'b0, 1'b1, 1'b1);        // same-cycle update not visible
    add_br(1'b1, 1'b0, 1'b0);
    add_ex(1'b1);
    add_br(1'b1, 1'b0, 1'b0);
    add_ex(1'b1); add_ex(1'b0); add_ex(1'b0);
    add_br(1'b0, 1'b0, 1'b0);
    add_ex(1'b0); add_ex(1'b0); add_ex(1'b1);
    add_br(1'b0, 1'b0, 1'b0);
    add_ex(1'b1);
    add_br(1'b1, 1'b0, 1'b0);
    // Call/return pair
    add_jal(32'h200, 32'h400, 1, 0);
    add_jr(32'h610, 0, 1, 1'b0, 1'b1, 32'h204, 1);
    add_idle(32'h0, 0);
    // Overflow past depth, then drain
    for (int i = 1; i <= 5; i++)
      add_jr(32'(i * 16), 1, 0, 1'b0, 1'b0, 32'(i * 16 + 4), (i - 1 > DEPTH) ? DEPTH : i - 1);
    add_jr(32'h900, 0, 1, 1'b0, 1'b1, 32'h54, 4);
    add_jr(32'h900, 0, 1, 1'b0, 1'b1, 32'h44, 3);
    add_jr(32'h900, 0, 1, 1'b0, 1'b1, 32'h34, 2);
    add_jr(32'h900, 0, 1, 1'b0, 1'b1, 32'h24, 1);
    add_jr(32'h900, 0, 1, 1'b0, 1'b0, 32'h904, 0);
    add_idle(32'h0, 0);
    // Stalled call and stalled return act once
    for (int i = 0; i < 3; i++) add_jr(32'h300, 1, 0, 1'b1, 1'b0, 32'h304, 0);
    add_jr(32'h300, 1, 0, 1'b0, 1'b0, 32'h304, 0);
    add_idle(32'h0, 1);
    for (int i = 0; i < 2; i++) add_jr(32'h310, 0, 1, 1'b1, 1'b1, 32'h304, 1);
    add_jr(32'h310, 0, 1, 1'b0, 1'b1, 32'h304, 1);
    add_jr(32'h320, 0, 1, 1'b0, 1'b0, 32'h324, 0);
    add_idle(32'h0, 0);
    // Coroutine swap, coroutine on empty, Rd==Rs1 call, odd return address
    add_jal(32'h84, 32'h10, 1, 0);
    add_jr(32'h700, 1, 5, 1'b0, 1'b1, 32'h88, 1);
    add_jr(32'h800, 0, 5, 1'b0, 1'b1, 32'h704, 1);
    add_idle(32'h0, 0);
    add_jr(32'h710, 5, 1, 1'b0, 1'b0, 32'h714, 0);
    add_jr(32'h714, 0, 1, 1'b0, 1'b1, 32'h714, 1);
    add_jr(32'h720, 1, 1, 1'b0, 1'b0, 32'h724, 0);
    add_jr(32'h730, 0, 1, 1'b0, 1'b1, 32'h724, 1);
    add_jal(32'h101, 32'h10, 5, 0);
    add_jr(32'h200, 0, 5, 1'b0, 1'b1, 32'h104, 1);
    v = vz(32'h50, 1'b0, 32'h54, 0); v.jal = 1'b1; v.rd = 5'd1; v.imme = 32'h8; vecs.push_back(v);
    add_idle(32'h0, 0);
    add_jal(32'h60, 32'h8, 0, 0);
    add_jr(32'h70, 0, 2, 1'b0, 1'b0, 32'h74, 0);
    add_jal(32'h1000, 32'hFFFF_FFF0, 0, 0);
    // Reset dominates pushes and BHT training
    add_jr(32'h400, 1, 0, 1'b0, 1'b0, 32'h404, 0);
    add_jr(32'h410, 1, 0, 1'b0, 1'b0, 32'h414, 1);
    add_rst_call(1'b0);
    add_idle(32'h100, 0);
    add_br(1'b0, 1'b0, 1'b0);
    add_jr(32'h420, 1, 0, 1'b1, 1'b0, 32'h424, 0);
    add_rst_call(1'b1);
    add_idle(32'h0, 0);

    foreach (vecs[i]) run(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int          cls;
      logic [11:0] r;
      logic [4:0]  regs [5];
      regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd2; regs[4] = 5'($urandom);
      v = '{default: 0};
      v.rst   = ($urandom_range(0, 99) == 0);
      v.valid = ($urandom_range(0, 99) < 85);
      v.stall = ($urandom_range(0, 3) == 0);
      cls = $urandom_range(0, 3);
      v.jal = (cls == 1); v.jalr = (cls == 2); v.btype = (cls == 3);
      v.rd  = regs[$urandom_range(0, 4)];
      v.rs1 = regs[$urandom_range(0, 4)];
      v.pc  = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) v.pc = v.pc | 32'd1;
      r = 12'($urandom);
      v.imme = {{20{r[11]}}, r[11:1], 1'b0};
      v.exv  = $urandom_range(0, 1);
      v.expc = 32'($urandom_range(0, 255)) << 2;
      v.ext  = $urandom_range(0, 1);
      run(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
